// File: rtl/fetch_unit.sv
// Instruction fetch with FIFO_DEPTH-entry prefetch buffer; optional FetchCount via `FETCH_PERF_EN.
// Latency: acked word visible on Ins one cycle after the ack edge; one request outstanding at most.
// Backpressure: Stall holds the head entry; requests pause while the buffer is full.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Redirect,
    input  logic [31:0] Target,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRdata,
    output logic [31:0] Ins,
    output logic        InsValid,
    output logic [31:0] PC4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t          state, next_state;
    logic            run;
    logic [31:0]     pc, pc_plus4, req_addr;
    logic [31:0]     ins_mem [FIFO_DEPTH];
    logic [31:0]     pc4_mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic            full, push, pop;

    assign pc_plus4 = pc + 32'd4;
    assign full     = (count == DEPTH_L);
    assign InsValid = (count != '0);
    assign Ins      = InsValid ? ins_mem[rd_ptr] : 32'h0;
    assign PC4      = InsValid ? pc4_mem[rd_ptr] : 32'h0;
    assign pop      = InsValid && !Stall && !Redirect;

    // IDLE presents the request combinationally so a same-cycle ack completes it without visiting WAIT.
    always_comb begin
        next_state = state;
        IMemReq    = 1'b0;
        IMemAddr   = req_addr;
        push       = 1'b0;
        case (state)
            IDLE: begin
                IMemAddr = pc;
                if (run && !full && !Redirect) begin
                    IMemReq = 1'b1;
                    if (IMemAck) push = 1'b1;
                    else         next_state = WAIT;
                end
            end
            WAIT: begin
                IMemReq = 1'b1;
                if (IMemAck) begin
                    push       = !Redirect;
                    next_state = IDLE;
                end else if (Redirect) begin
                    next_state = DISCARD;
                end
            end
            DISCARD: begin
                IMemReq = 1'b1;
                if (IMemAck) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // req_addr freezes the in-flight address so DISCARD keeps it stable after PC moves.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            run      <= 1'b0;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            run <= 1'b1;
            if (state == IDLE) req_addr <= pc;
            if (Redirect) begin
                pc     <= Target & ~32'h3;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc_plus4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            ins_mem[wr_ptr] <= IMemRdata;
            pc4_mem[wr_ptr] <= pc_plus4;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)     FetchCount <= 32'h0;
        else if (pop) FetchCount <= FetchCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory model returns addr + 0x1000_0000 after mem_lat cycles.
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        Redirect;
    logic [31:0] Target;
    logic        Stall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;
    logic [31:0] Ins;
    logic        InsValid;
    logic [31:0] PC4;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
`endif

    logic        mem_en;
    logic        force_ack;
    int          mem_lat;
    int          mem_cnt;
    int          checks;
    int          errors;
    int          pushes;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .Redirect(Redirect),
        .Target(Target),
        .Stall(Stall),
        .IMemReq(IMemReq),
        .IMemAddr(IMemAddr),
        .IMemAck(IMemAck),
        .IMemRdata(IMemRdata),
        .Ins(Ins),
        .InsValid(InsValid),
        .PC4(PC4)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount(FetchCount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign IMemAck   = force_ack | (mem_en && IMemReq && (mem_cnt >= mem_lat));
    assign IMemRdata = IMemAddr + 32'h1000_0000;

    always @(posedge CLK) begin
        if (IMemReq && !IMemAck) mem_cnt <= mem_cnt + 1;
        else                     mem_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; pushes = 0; mem_cnt = 0;
        RST = 1'b0; Redirect = 1'b0; Target = 32'h0; Stall = 1'b0;
        mem_en = 1'b1; mem_lat = 0; force_ack = 1'b0;

        repeat (2) @(negedge CLK);
        chk("rst_req",   32'(IMemReq),  32'd0);
        chk("rst_addr",  IMemAddr,      32'h0);
        chk("rst_valid", 32'(InsValid), 32'd0);
        chk("rst_ins",   Ins,           32'h0);
        chk("rst_pc4",   PC4,           32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_cnt",   FetchCount,    32'd0);
`endif

        // back-to-back stream with zero-latency memory
        RST = 1'b1;
        @(negedge CLK);
        chk("first_req",   32'(IMemReq),  32'd1);
        chk("first_addr",  IMemAddr,      32'h0);
        chk("first_valid", 32'(InsValid), 32'd0);
        @(negedge CLK);
        chk("s0_ins", Ins, 32'h1000_0000);
        chk("s0_pc4", PC4, 32'h4);
        @(negedge CLK);
        chk("s1_ins", Ins, 32'h1000_0004);
        chk("s1_pc4", PC4, 32'h8);
        @(negedge CLK);
        chk("s2_ins", Ins, 32'h1000_0008);
        chk("s2_pc4", PC4, 32'hC);

        // stall: buffer fills to 4 entries, then requests stop
        Stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (IMemReq && IMemAck) pushes++;
            chk("stall_ins", Ins, 32'h1000_0008);
            chk("stall_pc4", PC4, 32'hC);
            @(negedge CLK);
        end
        chk("stall_req",    32'(IMemReq), 32'd0);
        chk("stall_pushes", 32'(pushes),  32'd3);

        Stall = 1'b0;
        @(negedge CLK);
        chk("unstall_ins", Ins, 32'h1000_000C);
        chk("unstall_pc4", PC4, 32'h10);

        // redirect with 3 entries buffered, misaligned target
        Stall = 1'b1; Redirect = 1'b1; Target = 32'h103;
        #1;
        chk("redir_noreq", 32'(IMemReq), 32'd0);
        @(negedge CLK);
        Redirect = 1'b0;
        #1;
        chk("redir_valid", 32'(InsValid), 32'd0);
        chk("redir_ins",   Ins,           32'h0);
        chk("redir_pc4",   PC4,           32'h0);
        chk("redir_req",   32'(IMemReq),  32'd1);
        chk("redir_addr",  IMemAddr,      32'h100);
        @(negedge CLK);
        chk("redir_ins1", Ins, 32'h1000_0100);
        chk("redir_pc41", PC4, 32'h104);

        // redirect twice while a 3-cycle request is outstanding
        mem_lat = 3;
        @(negedge CLK);
        chk("lat_req",  32'(IMemReq), 32'd1);
        chk("lat_addr", IMemAddr,     32'h104);
        Redirect = 1'b1; Target = 32'h80;
        @(negedge CLK);
        Target = 32'h40;
        #1;
        chk("disc_valid", 32'(InsValid), 32'd0);
        chk("disc_addr",  IMemAddr,      32'h104);
        @(negedge CLK);
        Redirect = 1'b0;
        #1;
        chk("disc_req",  32'(IMemReq), 32'd1);
        chk("disc_addr2", IMemAddr,    32'h104);
        chk("disc_ack",  32'(IMemAck), 32'd1);
        @(negedge CLK);
        chk("drop_valid", 32'(InsValid), 32'd0);
        chk("drop_req",   32'(IMemReq),  32'd1);
        chk("drop_addr",  IMemAddr,      32'h40);
        mem_lat = 0;
        @(negedge CLK);
        chk("tgt_ins",  Ins,            32'h1000_0040);
        chk("tgt_pc",   PC4 - 32'd4,    32'h40);

        // wrap at top of address space
        Redirect = 1'b1; Target = 32'hFFFF_FFFE;
        @(negedge CLK);
        Redirect = 1'b0;
        #1;
        chk("wrap_addr", IMemAddr,     32'hFFFF_FFFC);
        chk("wrap_req",  32'(IMemReq), 32'd1);
        @(negedge CLK);
        chk("wrap_ins",   Ins,           32'h0FFF_FFFC);
        chk("wrap_pc4",   PC4,           32'h0);
        chk("wrap_valid", 32'(InsValid), 32'd1);
        chk("wrap_next",  IMemAddr,      32'h0);

        // reset in the middle of an outstanding request; stale ack afterwards
        mem_lat = 5;
        @(negedge CLK);
        chk("mid_req", 32'(IMemReq), 32'd1);
        RST = 1'b0;
        #1;
        chk("mid_rst_req",   32'(IMemReq),  32'd0);
        chk("mid_rst_addr",  IMemAddr,      32'h0);
        chk("mid_rst_valid", 32'(InsValid), 32'd0);
        force_ack = 1'b1; mem_en = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        chk("rel_req", 32'(IMemReq), 32'd0);
        @(negedge CLK);
        chk("stale_valid", 32'(InsValid), 32'd0);
`ifdef FETCH_PERF_EN
        chk("cnt_zero", FetchCount, 32'd0);
`endif
        force_ack = 1'b0; mem_en = 1'b1; mem_lat = 0; Stall = 1'b0;
        @(negedge CLK);
        chk("rel_ins", Ins, 32'h1000_0000);
        chk("rel_pc4", PC4, 32'h4);

        // five pops, then a flush that must not count
        repeat (5) @(negedge CLK);
        chk("pop5_ins", Ins, 32'h1000_0014);
        chk("pop5_pc4", PC4, 32'h18);
        Redirect = 1'b1; Target = 32'h200;
        @(negedge CLK);
        Redirect = 1'b0;
        chk("flush_valid", 32'(InsValid), 32'd0);
`ifdef FETCH_PERF_EN
        chk("cnt_five", FetchCount, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
